seq_det_sched: RTL and testbench

//  Scheduler that shares one serial Mealy sequence detector between two word requesters.
//  - Round-robin arbitration between the requesters.
//  - For each accepted word: clears the detector, then shifts the word into it bit-serially, MSB first.
//  - Counts the cycles in which the detector output is high, and returns the count with the

---
 rtl/seq_det_sched.sv | 159 +++++++++++++++
 tb/tb_seq_det_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler that shares one serial Mealy sequence detector
// between two word requesters and reports each word's hit count over a valid/ready port.
module seq_det_sched #(
  parameter int W    = 8,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [W-1:0]    req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [W-1:0]    req1_data,
  output logic            req1_ready,
  output logic            det_x,
  output logic            det_rst_n,
  input  logic            det_y,
  output logic            res_valid,
  output logic            res_src,
  output logic [CNTW-1:0] res_hits,
  input  logic            res_ready,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLR    = 2'd1,
    SHIFT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int              BCW      = (W > 2) ? $clog2(W) : 1;
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(W - 1);
  localparam logic [CNTW-1:0] HIT_MAX  = {CNTW{1'b1}};

  state_t          state_r;
  state_t          state_nxt_s;
  logic [W-1:0]    shift_r;
  logic [W-1:0]    shift_nxt_s;
  logic [BCW-1:0]  bit_cnt_r;
  logic [CNTW-1:0] hits_r;
  logic            src_r;
  logic            prio_r;
  logic            gnt_s;
  logic            idle_s;
  logic            accept_s;
  logic            det_x_r;
  logic            det_rst_n_r;
  logic            res_valid_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = CLR;
        else          state_nxt_s = IDLE;
      end
      CLR:   state_nxt_s = SHIFT;
      SHIFT: begin
        if (bit_cnt_r == LAST_BIT) state_nxt_s = REPORT;
        else                       state_nxt_s = SHIFT;
      end
      REPORT: begin
        if (res_ready) state_nxt_s = IDLE;
        else           state_nxt_s = REPORT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant selection; prio_r names the requester that wins a tie
  always_comb begin
    if (req0_valid && req1_valid) begin
      gnt_s = prio_r;
    end else if (req1_valid) begin
      gnt_s = 1'b1;
    end else if (req0_valid) begin
      gnt_s = 1'b0;
    end else begin
      gnt_s = prio_r;
    end
  end

  // Output decode: readies only while idle, and only for the granted requester
  always_comb begin
    idle_s     = (state_r == IDLE);
    req0_ready = idle_s && !gnt_s;
    req1_ready = idle_s && gnt_s;
    busy       = !idle_s;
    accept_s   = gnt_s ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
  end

  // Shift-register advance while bits are being sent
  always_comb begin
    if (state_r == SHIFT) begin
      shift_nxt_s = {shift_r[W-2:0], 1'b0};
    end else begin
      shift_nxt_s = shift_r;
    end
  end

  // Job datapath: word latch, bit counter, saturating hit counter, source and priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
      hits_r    <= '0;
      src_r     <= 1'b0;
      prio_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        shift_r <= gnt_s ? req1_data : req0_data;
        src_r   <= gnt_s;
        prio_r  <= ~gnt_s;
        hits_r  <= '0;
      end else begin
        shift_r <= shift_nxt_s;
      end
      if (state_r == SHIFT) begin
        bit_cnt_r <= bit_cnt_r + BCW'(1);
        if (det_y && (hits_r != HIT_MAX)) begin
          hits_r <= hits_r + CNTW'(1);
        end
      end else begin
        bit_cnt_r <= '0;
      end
    end
  end

  // Registered detector drive and result valid, computed from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_x_r     <= 1'b0;
      det_rst_n_r <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      det_rst_n_r <= (state_nxt_s != CLR);
      det_x_r     <= (state_nxt_s == SHIFT) ? shift_nxt_s[W-1] : 1'b0;
      res_valid_r <= (state_nxt_s == REPORT);
    end
  end

  assign det_x     = det_x_r;
  assign det_rst_n = det_rst_n_r;
  assign res_valid = res_valid_r;
  assign res_src   = src_r;
  assign res_hits  = hits_r;

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: randomized self-checking bench; the detector is a loopback (det_y = det_x)
// so each job's expected hit count is the number of ones in the granted word.
module tb_seq_det_sched;
  localparam int W    = 8;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req0_valid = 1'b0;
  logic [W-1:0]    req0_data  = '0;
  logic            req0_ready;
  logic            req1_valid = 1'b0;
  logic [W-1:0]    req1_data  = '0;
  logic            req1_ready;
  logic            det_x;
  logic            det_rst_n;
  logic            det_y;
  logic            res_valid;
  logic            res_src;
  logic [CNTW-1:0] res_hits;
  logic            res_ready = 1'b0;
  logic            busy;
  logic            y_noise = 1'b0;

  logic            s_v0 = 1'b0;
  logic            s_r0, s_r1, s_x, s_rn, s_rv, s_src, s_busy;
  logic [2:0]      s_hits;

  int  n_chk = 0;
  int  n_bad = 0;
  logic pref = 1'b0;
  time acc_t = 0;

  always #5 clk = ~clk;

  // detector model: plain loopback, plus deliberate noise outside the bit window
  assign det_y = det_x | y_noise;

  seq_det_sched #(.W(W), .CNTW(CNTW)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_x(det_x), .det_rst_n(det_rst_n), .det_y(det_y),
    .res_valid(res_valid), .res_src(res_src), .res_hits(res_hits),
    .res_ready(res_ready), .busy(busy)
  );

  seq_det_sched #(.W(8), .CNTW(3)) u_sat (
    .clk(clk), .rst(rst),
    .req0_valid(s_v0), .req0_data(8'h00), .req0_ready(s_r0),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(s_r1),
    .det_x(s_x), .det_rst_n(s_rn), .det_y(1'b1),
    .res_valid(s_rv), .res_src(s_src), .res_hits(s_hits),
    .res_ready(1'b1), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_hits(input logic [W-1:0] d, input int cntw);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(d[i]);
    if (n > (1 << cntw) - 1) n = (1 << cntw) - 1;
    return n;
  endfunction

  // one complete job from an idle DUT; stall = extra REPORT cycles with res_ready low
  task automatic run_job(input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1, input int stall);
    logic         src;
    logic [W-1:0] d;
    int           hits;
    @(negedge clk);
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    res_ready  = (stall == 0);
    y_noise    = 1'b1;
    src  = (v0 && v1) ? pref : v1;
    d    = src ? d1 : d0;
    hits = exp_hits(d, CNTW);
    #1;
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_rstn", 32'(det_rst_n), 32'(1));
    chk("rdy0", 32'(req0_ready), 32'(!src));
    chk("rdy1", 32'(req1_ready), 32'(src));
    @(posedge clk);
    pref  = !src;
    acc_t = $time;
    @(negedge clk);
    req0_data = W'($urandom);
    req1_data = W'($urandom);
    #1;
    chk("clr_rstn", 32'(det_rst_n), 32'(0));
    chk("clr_x", 32'(det_x), 32'(0));
    chk("clr_busy", 32'(busy), 32'(1));
    chk("clr_rdy", 32'({req0_ready, req1_ready}), 32'(0));
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      y_noise = 1'b0;
      #1;
      chk("bit_x", 32'(det_x), 32'(d[W-1-i]));
      chk("bit_rstn", 32'(det_rst_n), 32'(1));
      chk("bit_vld", 32'(res_valid), 32'(0));
      chk("bit_rdy", 32'({req0_ready, req1_ready}), 32'(0));
    end
    @(negedge clk);
    y_noise = 1'b1;
    #1;
    chk("res_vld", 32'(res_valid), 32'(1));
    chk("res_src", 32'(res_src), 32'(src));
    chk("res_hits", 32'(res_hits), 32'(hits));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      chk("hold_vld", 32'(res_valid), 32'(1));
      chk("hold_src", 32'(res_src), 32'(src));
      chk("hold_hits", 32'(res_hits), 32'(hits));
      chk("hold_rdy", 32'({req0_ready, req1_ready}), 32'(0));
    end
    res_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time  prev;
    logic found;
    int   sel;
    #2;
    chk("rst_rstn", 32'(det_rst_n), 32'(0));
    chk("rst_x", 32'(det_x), 32'(0));
    chk("rst_vld", 32'(res_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_hits", 32'(res_hits), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // both requesters valid continuously: sources alternate starting with 0
    for (int j = 0; j < 4; j++) run_job(1'b1, 8'hFF, 1'b1, 8'h01, 0);
    // single requester, latency and bit order
    run_job(1'b1, 8'hA5, 1'b0, 8'h00, 0);
    // consumer stall in REPORT
    run_job(1'b1, 8'h3C, 1'b0, 8'h00, 5);

    // grant follows a dropped valid within an idle cycle
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("arb_both0", 32'(req0_ready), 32'(!pref));
    chk("arb_both1", 32'(req1_ready), 32'(pref));
    if (pref) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
    #1;
    chk("arb_drop0", 32'(req0_ready), 32'(pref));
    chk("arb_drop1", 32'(req1_ready), 32'(!pref));
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);

    // back-to-back requester 1 only: accepts W+3 cycles apart
    for (int j = 0; j < 4; j++) begin
      prev = acc_t;
      run_job(1'b0, W'($urandom), 1'b1, W'($urandom), 0);
      if (j > 0) chk("b2b_gap", 32'((acc_t - prev) / 10), 32'(W + 3));
    end

    // reset during the third bit cycle discards the job
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hA5; req1_valid = 1'b0; res_ready = 1'b1; y_noise = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rstn", 32'(det_rst_n), 32'(0));
    chk("mid_x", 32'(det_x), 32'(0));
    chk("mid_vld", 32'(res_valid), 32'(0));
    chk("mid_src", 32'(res_src), 32'(0));
    chk("mid_hits", 32'(res_hits), 32'(0));
    chk("mid_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst  = 1'b0;
    pref = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      #1;
      chk("post_rst_novld", 32'(res_valid), 32'(0));
    end
    run_job(1'b1, 8'hA5, 1'b1, 8'h5A, 0);

    // randomized jobs
    for (int j = 0; j < 20; j++) begin
      sel = $urandom_range(1, 3);
      run_job(sel[0], W'($urandom), sel[1], W'($urandom), $urandom_range(0, 3));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // saturation: det_y stuck high, 3-bit counter
    @(negedge clk);
    s_v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_v0  = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #1;
      if (s_rv) found = 1'b1;
    end
    chk("sat_seen", 32'(found), 32'(1));
    if (found) begin
      chk("sat_hits", 32'(s_hits), 32'(7));
      chk("sat_src", 32'(s_src), 32'(0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
